alu_exec_stage: RTL and testbench

//  Registered execute stage that consumes the 3-bit ALU control code and the two operands and produces a result and flags.

---
 rtl/alu_exec_stage_pkg.sv | 26 ++
 rtl/alu_exec_stage_core.sv | 37 +++
 rtl/alu_exec_stage.sv | 129 ++++++++++++
 tb/tb_alu_exec_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Package alu_pkg: shared constants for the ALU execute stage.
//   - ALU_* : 3-bit ALU control codes from the ALU control unit.
//   - ALU_DEFAULT_WIDTH / ALU_DEFAULT_RAW : default operand and
//     register-address widths used by alu_exec_stage and alu_core.
//   - alu_payload_t : buffer entry layout at the default widths.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam int ALU_DEFAULT_WIDTH = 32;
    localparam int ALU_DEFAULT_RAW   = 5;

    // Buffer entry: computed results only, never operands.
    typedef struct packed {
        logic [ALU_DEFAULT_WIDTH-1:0] result;
        logic                         zero;
        logic                         illegal;
        logic [ALU_DEFAULT_RAW-1:0]   rd_addr;
        logic                         reg_write;
    } alu_payload_t;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Module alu_core: purely combinational ALU datapath.
// Ports:
//   ctrl    in   3      ALU control code (see alu_pkg)
//   a, b    in   WIDTH  operands
//   result  out  WIDTH  ALU result (0 for illegal codes)
//   zero    out  1      result == 0
//   illegal out  1      ctrl is 101/110/111
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase
    end

    // Illegal codes leave result at 0, so zero naturally reads 1.
    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Module alu_exec_stage: registered ALU execute stage with valid/ready
// handshakes and a two-entry elastic buffer (main + skid).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        upstream handshake (in_ready registered)
//   alu_ctrl, src_a, src_b     op code and operands
//   rd_addr, reg_write         passed through with the op
//   out_valid / out_ready      downstream handshake
//   result, zero, illegal      computed outputs (from main entry)
//   out_rd_addr, out_reg_write passed-through fields (reg_write masked
//                              when the op was illegal)
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH,
    parameter int RAW   = ALU_DEFAULT_RAW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [RAW-1:0]   rd_addr,
    input  logic             reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [RAW-1:0]   out_rd_addr,
    output logic             out_reg_write
);

    // Local entry type so non-default WIDTH/RAW overrides stay consistent.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             illegal;
        logic [RAW-1:0]   rd_addr;
        logic             reg_write;
    } payload_t;

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_illegal;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .ctrl    (alu_ctrl),
        .a       (src_a),
        .b       (src_b),
        .result  (core_result),
        .zero    (core_zero),
        .illegal (core_illegal)
    );

    payload_t main_reg, main_next;
    payload_t skid_reg, skid_next;
    logic     main_valid_reg, main_valid_next;
    logic     skid_valid_reg, skid_valid_next;
    logic     in_ready_reg;
    payload_t new_entry;
    logic     accept;
    logic     drain;

    always_comb begin
        new_entry.result    = core_result;
        new_entry.zero      = core_zero;
        new_entry.illegal   = core_illegal;
        new_entry.rd_addr   = rd_addr;
        new_entry.reg_write = reg_write & ~core_illegal;
    end

    assign accept = in_valid && in_ready_reg;
    assign drain  = main_valid_reg && out_ready;

    // in_ready_reg is low whenever skid holds an op, so an accept never
    // coincides with a full skid.
    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (drain) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_next = new_entry;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_reg) begin
                skid_next       = new_entry;
                skid_valid_next = 1'b1;
            end else begin
                main_next       = new_entry;
                main_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= !skid_valid_next;
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = main_valid_reg;
    assign result        = main_reg.result;
    assign zero          = main_reg.zero;
    assign illegal       = main_reg.illegal;
    assign out_rd_addr   = main_reg.rd_addr;
    assign out_reg_write = main_reg.reg_write;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + randomised self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    int checks = 0;
    int errors = 0;

    alu_exec_stage #(.WIDTH(32), .RAW(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_ctrl      (alu_ctrl),
        .src_a         (src_a),
        .src_b         (src_b),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .illegal       (illegal),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rw);
        in_valid  = 1'b1;
        alu_ctrl  = c;
        src_a     = a;
        src_b     = b;
        rd_addr   = rd;
        reg_write = rw;
    endtask

    // Independent reference: {result, zero, illegal, rd, reg_write}
    function automatic logic [39:0] model(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] rd,
                                          input logic rw);
        logic [31:0] r;
        logic        ill;
        r   = 32'd0;
        ill = 1'b0;
        case (c)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
        return {r, (r == 32'd0), ill, rd, rw & ~ill};
    endfunction

    logic [39:0] q[$];
    logic [39:0] exp_e;
    logic [39:0] obs_e;
    int          sent;
    int          cycles;
    logic        hold;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 3'd0; src_a = '0; src_b = '0; rd_addr = '0; reg_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_payload", 64'({result, zero, illegal, out_rd_addr, out_reg_write}), 64'd0);
        reset = 1'b0;

        // 1: fill main + skid, then reset mid-stream
        set_op(3'd0, 32'd10, 32'd20, 5'd1, 1'b1); tick;
        set_op(3'd0, 32'd30, 32'd40, 5'd2, 1'b1); tick;
        check("fill_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1; in_valid = 1'b0; tick;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_result", 64'(result), 64'd0);
        reset = 1'b0; out_ready = 1'b1;
        set_op(3'd0, 32'd1, 32'd2, 5'd3, 1'b1); tick;
        check("post_rst_first", 64'({out_valid, result, out_rd_addr}), 64'({1'b1, 32'd3, 5'd3}));
        in_valid = 1'b0; tick;
        check("post_rst_empty", 64'(out_valid), 64'd0);

        // 2: back-to-back, latency 1
        set_op(3'd0, 32'd5, 32'd7, 5'd4, 1'b1); tick;
        check("b2b_add", 64'({out_valid, result}), 64'({1'b1, 32'h0000000C}));
        set_op(3'd1, 32'd5, 32'd7, 5'd4, 1'b1); tick;
        check("b2b_sub", 64'({out_valid, result}), 64'({1'b1, 32'hFFFFFFFE}));
        set_op(3'd2, 32'hF0, 32'h3C, 5'd4, 1'b1); tick;
        check("b2b_and", 64'({out_valid, result}), 64'({1'b1, 32'h00000030}));
        set_op(3'd3, 32'hF0, 32'h0F, 5'd4, 1'b1); tick;
        check("b2b_or", 64'({out_valid, result, in_ready}), 64'({1'b1, 32'h000000FF, 1'b1}));

        // 3: SLT and zero flag
        set_op(3'd4, 32'hFFFFFFFF, 32'd1, 5'd5, 1'b1); tick;
        check("slt_neg_lt", 64'({result, zero}), 64'({32'd1, 1'b0}));
        set_op(3'd4, 32'd1, 32'hFFFFFFFF, 5'd5, 1'b1); tick;
        check("slt_pos_ge", 64'({result, zero}), 64'({32'd0, 1'b1}));
        set_op(3'd1, 32'd9, 32'd9, 5'd5, 1'b1); tick;
        check("sub_zero", 64'({result, zero, illegal}), 64'({32'd0, 1'b1, 1'b0}));
        in_valid = 1'b0; tick;
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // 4: stall three cycles, then release
        out_ready = 1'b0;
        set_op(3'd0, 32'd1, 32'd1, 5'd6, 1'b1); tick;
        check("stall_c1", 64'({out_valid, result, in_ready}), 64'({1'b1, 32'd2, 1'b1}));
        set_op(3'd0, 32'd2, 32'd2, 5'd7, 1'b1); tick;
        check("stall_c2", 64'({out_valid, result, in_ready}), 64'({1'b1, 32'd2, 1'b0}));
        set_op(3'd0, 32'd3, 32'd3, 5'd8, 1'b1); tick;
        check("stall_c3", 64'({out_valid, result, out_rd_addr, in_ready}), 64'({1'b1, 32'd2, 5'd6, 1'b0}));
        out_ready = 1'b1; tick;
        check("release_skid", 64'({out_valid, result, out_rd_addr, in_ready}), 64'({1'b1, 32'd4, 5'd7, 1'b1}));
        tick;
        check("release_held", 64'({out_valid, result, out_rd_addr}), 64'({1'b1, 32'd6, 5'd8}));
        in_valid = 1'b0; tick;
        check("release_empty", 64'(out_valid), 64'd0);

        // 5: illegal code
        set_op(3'b110, 32'd5, 32'd3, 5'd7, 1'b1); tick;
        check("illegal", 64'({out_valid, result, zero, illegal, out_reg_write, out_rd_addr}),
              64'({1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 5'd7}));
        in_valid = 1'b0; tick;

        // 6: random valid/ready with scoreboard
        sent = 0; cycles = 0; hold = 1'b0;
        while ((sent < 10000 || q.size() > 0) && cycles < 60000) begin
            if (!hold) begin
                if (sent < 10000 && $urandom_range(0, 3) != 0) begin
                    set_op(3'($urandom_range(0, 7)),
                           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                obs_e = {result, zero, illegal, out_rd_addr, out_reg_write};
                if (q.size() == 0) begin
                    check("rand_dup", 64'd1, 64'd0);
                end else begin
                    exp_e = q.pop_front();
                    check("rand_out", 64'(obs_e), 64'(exp_e));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(alu_ctrl, src_a, src_b, rd_addr, reg_write));
                sent++;
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        check("rand_all_sent", 64'(sent), 64'd10000);
        check("rand_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
